// File: rtl/intf_int_ctrl.sv
// Multi-channel interrupt controller: sticky per-source flags with enable, mask,
// write-1-to-clear and level/edge mode, coalesced into one registered irq plus id.
module intf_int_ctrl #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int unsigned THR_W   = $clog2(NUM_SRC + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] en,
  input  logic [NUM_SRC-1:0] mode,
  input  logic [NUM_SRC-1:0] msk,
  input  logic [NUM_SRC-1:0] clr,
  input  logic [THR_W-1:0]   thr,
  output logic [NUM_SRC-1:0] fl,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [NUM_SRC-1:0] fl_q, fl_d;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] set;
  logic [NUM_SRC-1:0] pend;
  logic [THR_W-1:0]   pcnt;
  logic [THR_W-1:0]   thr_eff;
  logic               tmr_hit;

  // Set takes priority over clear so an event coinciding with a clear is kept.
  always_comb begin
    src_prev_d = src;
    rise       = src & ~src_prev_q;
    set        = en & ((mode & rise) | (~mode & src));
    fl_d       = set | (fl_q & ~clr);
  end

  always_comb begin
    pend    = fl_q & ~msk;
    pcnt    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pcnt = pcnt + THR_W'(pend[i]);
    end
    thr_eff = (thr == '0) ? THR_W'(1) : thr;
    irq_d   = (pend != '0) && (irq_q || (pcnt >= thr_eff) || tmr_hit);
    irq_id_d = '0;
    if (irq_d) begin
      for (int unsigned i = NUM_SRC; i > 0; i--) begin
        if (pend[i-1]) irq_id_d = ID_W'(i - 1);
      end
    end
  end

  if (TIMEOUT != 0) begin : g_tmr
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Counts cycles with something pending but irq not yet raised; saturates.
    always_comb begin
      if ((pend == '0) || irq_q)            tmr_d = '0;
      else if (tmr_q == TMR_W'(TIMEOUT))    tmr_d = tmr_q;
      else                                  tmr_d = tmr_q + TMR_W'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) tmr_q <= '0;
      else     tmr_q <= tmr_d;
    end

    assign tmr_hit = (tmr_q == TMR_W'(TIMEOUT));
  end else begin : g_no_tmr
    assign tmr_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev_q <= '0;
      fl_q       <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      src_prev_q <= src_prev_d;
      fl_q       <= fl_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign fl     = fl_q;
  assign irq    = irq_q;
  assign irq_id = irq_id_q;

endmodule

// File: tb/tb_intf_int_ctrl.sv
// Bench for intf_int_ctrl: vector table, directed coalescing sequences and a
// randomized run, with TIMEOUT=4 and TIMEOUT=0 instances checked against a model.
module tb_intf_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src, en, mode, msk, clr;
  logic [3:0] thr;
  logic [7:0] fl_a, fl_b;
  logic       irq_a, irq_b;
  logic [2:0] id_a, id_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  intf_int_ctrl #(.NUM_SRC(8), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .src(src), .en(en), .mode(mode), .msk(msk),
    .clr(clr), .thr(thr), .fl(fl_a), .irq(irq_a), .irq_id(id_a)
  );

  intf_int_ctrl #(.NUM_SRC(8), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .src(src), .en(en), .mode(mode), .msk(msk),
    .clr(clr), .thr(thr), .fl(fl_b), .irq(irq_b), .irq_id(id_b)
  );

  // Reference model: index 0 mirrors TIMEOUT=4, index 1 TIMEOUT=0
  int         m_to [2] = '{4, 0};
  logic [7:0] m_fl [2];
  bit         m_irq[2];
  int         m_id [2];
  int         m_age[2];
  logic [7:0] m_prev;

  task automatic model_update();
    logic [7:0] pend;
    int cnt, thr_e;
    bit fire, ev;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_fl[k] = 8'h00; m_irq[k] = 0; m_id[k] = 0; m_age[k] = 0;
      end else begin
        pend  = m_fl[k] & ~msk;
        cnt   = $countones(pend);
        thr_e = (thr == 0) ? 1 : int'(thr);
        fire  = (pend != 0) && (m_irq[k] || cnt >= thr_e ||
                                (m_to[k] != 0 && m_age[k] >= m_to[k]));
        m_age[k] = (pend == 0 || m_irq[k]) ? 0 :
                   ((m_age[k] < m_to[k]) ? m_age[k] + 1 : m_to[k]);
        m_irq[k] = fire;
        m_id[k]  = 0;
        if (fire) begin
          for (int i = 7; i >= 0; i--) if (pend[i]) m_id[k] = i;
        end
        for (int i = 0; i < 8; i++) begin
          ev = mode[i] ? (src[i] && !m_prev[i]) : src[i];
          if (en[i] && ev)  m_fl[k][i] = 1'b1;
          else if (clr[i])  m_fl[k][i] = 1'b0;
        end
      end
    end
    m_prev = rst ? 8'h00 : src;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("model_fl_a",  32'(fl_a),  32'(m_fl[0]));
    chk("model_irq_a", 32'(irq_a), 32'(m_irq[0]));
    chk("model_id_a",  32'(id_a),  32'(m_id[0]));
    chk("model_fl_b",  32'(fl_b),  32'(m_fl[1]));
    chk("model_irq_b", 32'(irq_b), 32'(m_irq[1]));
    chk("model_id_b",  32'(id_b),  32'(m_id[1]));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] src, mode, msk, clr;
    logic [7:0] e_fl;
    logic       e_irq;
    logic [2:0] e_id;
  } vec_t;

  function automatic vec_t mk(logic r, logic [7:0] s, logic [7:0] md, logic [7:0] mk_,
                              logic [7:0] c, logic [7:0] efl, logic eirq, logic [2:0] eid);
    vec_t v;
    v.rst = r; v.src = s; v.mode = md; v.msk = mk_; v.clr = c;
    v.e_fl = efl; v.e_irq = eirq; v.e_id = eid;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    // reset with sources high, then level flags appear on release
    vecs[0]  = mk(1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[1]  = mk(1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[2]  = mk(0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0);
    vecs[3]  = mk(0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 0);
    // edge (bit0) vs level (bit1) under a clear
    vecs[4]  = mk(1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[5]  = mk(0, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 0, 0);
    vecs[6]  = mk(0, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 1, 0);
    vecs[7]  = mk(0, 8'h03, 8'h01, 8'h00, 8'h03, 8'h02, 1, 0);
    vecs[8]  = mk(0, 8'h03, 8'h01, 8'h00, 8'h00, 8'h02, 1, 1);
    vecs[9]  = mk(0, 8'h03, 8'h01, 8'h00, 8'h00, 8'h02, 1, 1);
    // set/clear collision on edge-mode bit2
    vecs[10] = mk(0, 8'h04, 8'h05, 8'h00, 8'h00, 8'h06, 1, 1);
    vecs[11] = mk(0, 8'h00, 8'h05, 8'h00, 8'h00, 8'h06, 1, 1);
    vecs[12] = mk(0, 8'h04, 8'h05, 8'h00, 8'h04, 8'h06, 1, 1);
    vecs[13] = mk(0, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 1, 1);
    vecs[14] = mk(0, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 0, 0);
    // mask and priority
    vecs[15] = mk(0, 8'h28, 8'h00, 8'h08, 8'h00, 8'h28, 0, 0);
    vecs[16] = mk(0, 8'h00, 8'h00, 8'h08, 8'h00, 8'h28, 1, 5);
    vecs[17] = mk(0, 8'h00, 8'h00, 8'h28, 8'h00, 8'h28, 0, 0);
    vecs[18] = mk(0, 8'h00, 8'h00, 8'h28, 8'h00, 8'h28, 0, 0);
    vecs[19] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h28, 1, 3);

    rst = 1; src = '0; en = 8'hFF; mode = '0; msk = '0; clr = '0; thr = 4'd1;
    m_prev = '0;

    for (int v = 0; v < 20; v++) begin
      rst = vecs[v].rst; src = vecs[v].src; mode = vecs[v].mode;
      msk = vecs[v].msk; clr = vecs[v].clr;
      tick();
      chk($sformatf("vec%0d_fl", v),  32'(fl_a),  32'(vecs[v].e_fl));
      chk($sformatf("vec%0d_irq", v), 32'(irq_a), 32'(vecs[v].e_irq));
      chk($sformatf("vec%0d_id", v),  32'(id_a),  32'(vecs[v].e_id));
    end

    // coalescing by timeout, then by count, thr=3
    rst = 1; src = '0; mode = '0; msk = '0; clr = '0; thr = 4'd3;
    tick();
    rst = 0;
    tick();
    src = 8'h01;
    tick();
    chk("to_fl_k", 32'(fl_a), 32'h01);
    chk("to_irq_k", 32'(irq_a), 32'h0);
    src = '0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk($sformatf("to_irq_k%0d", j), 32'(irq_a), 32'h0);
    end
    tick();
    chk("to_irq_k5", 32'(irq_a), 32'h1);
    chk("to_id_k5",  32'(id_a),  32'h0);
    clr = 8'hFF;
    tick();
    chk("to_clr_fl",  32'(fl_a),  32'h00);
    chk("to_clr_irq", 32'(irq_a), 32'h1);
    clr = '0;
    tick();
    chk("to_clr_irq_next", 32'(irq_a), 32'h0);
    src = 8'h07;
    tick();
    chk("cnt_fl_k",  32'(fl_a),  32'h07);
    chk("cnt_irq_k", 32'(irq_a), 32'h0);
    src = '0;
    tick();
    chk("cnt_irq_k1", 32'(irq_a), 32'h1);

    // TIMEOUT=0 instance: only the count threshold raises irq
    clr = 8'hFF;
    tick();
    clr = '0; thr = 4'd2;
    tick();
    chk("nto_idle_irq", 32'(irq_b), 32'h0);
    src = 8'h01;
    tick();
    src = '0;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk($sformatf("nto_hold_irq%0d", j), 32'(irq_b), 32'h0);
    end
    src = 8'h02;
    tick();
    chk("nto_fl2",  32'(fl_b),  32'h03);
    chk("nto_irq2", 32'(irq_b), 32'h0);
    src = '0;
    tick();
    chk("nto_irq_up", 32'(irq_b), 32'h1);
    chk("nto_id_up",  32'(id_b),  32'h0);
    clr = 8'h03;
    tick();
    chk("nto_clr_fl",  32'(fl_b),  32'h00);
    chk("nto_clr_irq", 32'(irq_b), 32'h1);
    clr = '0;
    tick();
    chk("nto_irq_down", 32'(irq_b), 32'h0);
    chk("nto_id_down",  32'(id_b),  32'h0);

    // randomized run, including occasional mid-operation resets
    for (int c = 0; c < 500; c++) begin
      rst  = ($urandom_range(0, 39) == 0);
      src  = 8'($urandom & $urandom & $urandom);
      en   = 8'($urandom | $urandom);
      mode = 8'($urandom);
      msk  = 8'($urandom & $urandom);
      clr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 7) == 0) thr = 4'($urandom_range(0, 9));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
